// File: rtl/mprc_cache_pkg.sv
// Shared types and helpers for the data-cache store path.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mprc_cache_pkg;

    localparam int DW_BYTES  = 8;
    // Entry address field is sized for the widest physical address the
    // cache supports; narrower builds zero-extend into it.
    localparam int SMB_DWA_W = 61;

    typedef struct packed {
        logic                 valid;
        logic [SMB_DWA_W-1:0] dw_addr;
        logic [63:0]          data;
        logic [7:0]           mask;
    } smb_entry_t;

    // Overlay the enabled bytes of new_data onto old_data.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_data,
                                               input logic [63:0] new_data,
                                               input logic [7:0]  mask);
        logic [63:0] res;
        res = old_data;
        for (int i = 0; i < DW_BYTES; i++) begin
            if (mask[i]) begin
                res[i*8 +: 8] = new_data[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mprc_smb_entry.sv
// One store-merge-buffer slot: allocate, byte-merge into, or retire a doubleword.
// Latency: updates are visible on entry the cycle after the control strobe.
// Backpressure: none locally; the owner guarantees alloc/merge/clear are exclusive.
module mprc_smb_entry import mprc_cache_pkg::*; (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc,
    input  logic                 merge,
    input  logic                 clear,
    input  logic [SMB_DWA_W-1:0] dw_addr,
    input  logic [63:0]          data,
    input  logic [7:0]           mask,
    output smb_entry_t           entry
);

    smb_entry_t entry_q;

    // Slot state: fresh allocation overwrites, merge overlays bytes, clear retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (alloc) begin
            entry_q.valid   <= 1'b1;
            entry_q.dw_addr <= dw_addr;
            entry_q.data    <= data;
            entry_q.mask    <= mask;
        end else if (merge) begin
            entry_q.data <= byte_merge(entry_q.data, data, mask);
            entry_q.mask <= entry_q.mask | mask;
        end else if (clear) begin
            entry_q.valid <= 1'b0;
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/mprc_store_merge_buffer.sv
// In-order store buffer that merges same-doubleword stores into the youngest entry.
// Latency: an accepted store appears on wr_* the next cycle; no pass-through.
// Backpressure: req_ready = count < DEPTH from registered state only; wr_* hold while !wr_ready.
// Optional load forwarding port set is built when MPRC_SMB_LOAD_FWD_EN is defined.
module mprc_store_merge_buffer import mprc_cache_pkg::*; #(
    parameter int DEPTH   = 4,
    parameter int PADDR_W = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [PADDR_W-1:0]       req_addr,
    input  logic [63:0]              req_data,
    input  logic [7:0]               req_mask,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [PADDR_W-4:0]       wr_addr,
    output logic [63:0]              wr_data,
    output logic [7:0]               wr_mask,
`ifdef MPRC_SMB_LOAD_FWD_EN
    input  logic [PADDR_W-4:0]       fwd_addr,
    output logic [7:0]               fwd_mask,
    output logic [63:0]              fwd_data,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;
    logic [PTR_W-1:0]     young_idx;
    logic [SMB_DWA_W-1:0] req_dwa;
    logic                 enq;
    logic                 deq;
    logic                 merge_hit;
    logic                 do_merge;
    logic                 do_alloc;
    logic                 unused_low_addr;

    smb_entry_t ent [DEPTH];

    // Byte offset within the doubleword plays no part in buffering.
    assign unused_low_addr = ^req_addr[2:0];

    assign req_dwa   = SMB_DWA_W'(req_addr[PADDR_W-1:3]);
    assign req_ready = (count_q < DEPTH_C);
    assign wr_valid  = (count_q != '0);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign deq       = wr_valid && wr_ready;
    // An all-zero mask is accepted but writes nothing, so it never enqueues.
    assign enq       = req_valid && req_ready && (req_mask != 8'h00);
    assign young_idx = tail_q - 1'b1;

    // Merge only into the youngest entry, and never into a head that is leaving now.
    assign merge_hit = (count_q != '0) && ent[young_idx].valid
                    && (ent[young_idx].dw_addr == req_dwa)
                    && !((count_q == ONE_C) && deq);
    assign do_merge  = enq && merge_hit;
    assign do_alloc  = enq && !merge_hit;

    assign wr_addr = ent[head_q].dw_addr[PADDR_W-4:0];
    assign wr_data = ent[head_q].data;
    assign wr_mask = ent[head_q].mask;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        mprc_smb_entry u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .alloc   (do_alloc && (tail_q == PTR_W'(g))),
            .merge   (do_merge && (young_idx == PTR_W'(g))),
            .clear   (deq && (head_q == PTR_W'(g))),
            .dw_addr (req_dwa),
            .data    (req_data),
            .mask    (req_mask),
            .entry   (ent[g])
        );
    end

    // Ring pointers and occupancy; power-of-two depth makes the wrap implicit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_alloc) begin
                tail_q <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            case ({do_alloc, deq})
                2'b10:   count_q <= count_q + ONE_C;
                2'b01:   count_q <= count_q - ONE_C;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef MPRC_SMB_LOAD_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so a younger matching byte overrides an older one.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if (ent[fwd_idx].valid && (ent[fwd_idx].dw_addr == SMB_DWA_W'(fwd_addr))) begin
                for (int b = 0; b < DW_BYTES; b++) begin
                    if (ent[fwd_idx].mask[b]) begin
                        fwd_mask[b]        = 1'b1;
                        fwd_data[b*8 +: 8] = ent[fwd_idx].data[b*8 +: 8];
                    end
                end
            end
        end
    end
`endif

endmodule

// File: doc/mprc_store_merge_buffer.md
Name: mprc_store_merge_buffer

Overview:
- Sits directly downstream of the store-data generator in the non-blocking data cache.
- Accepts byte-replicated 64-bit store data plus byte mask, and buffers stores in a small in-order FIFO.
- Merges a new store into the youngest entry when both target the same doubleword.
- Drains entries in order to the data-array write port over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of doubleword entries; must be a power of 2, minimum 2.
- PADDR_W, 40, physical address width.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  store request valid
- req_ready  output  1  buffer can accept a request
- req_addr  input  PADDR_W  store byte address; bits [2:0] ignored
- req_data  input  64  aligned/replicated store data
- req_mask  input  8  byte-enable mask
- wr_valid  output  1  head entry valid toward data array
- wr_ready  input  1  data array accepts write
- wr_addr  output  PADDR_W-3  doubleword address of head entry
- wr_data  output  64  head entry data
- wr_mask  output  8  head entry byte mask
- count  output  clog2(DEPTH)+1  occupied entries
- empty  output  1  count == 0

Behaviour:
- Reset (rst_n low at a clk edge):
  - all entries invalid; head = tail = 0; count = 0.
  - wr_valid = 0, empty = 1, req_ready = 1.
  - Reset mid-drain discards all entries with no partial write.
- Handshakes:
  - Enqueue fires on req_valid && req_ready.
  - Dequeue fires on wr_valid && wr_ready.
  - req_ready = (count < DEPTH). It is registered-state only and never depends on req_addr or wr_ready, so there is no full-bypass.
- Outputs:
  - wr_valid = !empty.
  - wr_addr, wr_data and wr_mask come from the head entry registers. They are stable while wr_valid && !wr_ready.
- Latency: an allocated store is visible on wr_* the cycle after acceptance. There is no same-cycle pass-through.
- Merge condition (on enqueue): all of the following must hold.
  - count > 0.
  - req_addr[PADDR_W-1:3] equals the tail-1 entry address.
  - That entry is not being dequeued this cycle, i.e. NOT (count == 1 && dequeue fire).
- Merge action, per byte i: if req_mask[i], then data byte i = req_data byte i; entry mask |= req_mask. count is unchanged.
- Allocate (enqueue without merge): write the entry at tail; tail = tail+1 mod DEPTH; count+1.
- Dequeue: head = head+1 mod DEPTH; count-1.
- Simultaneous allocate and dequeue: count unchanged; both pointers advance.
- req_mask == 0: accepted (when req_ready) and discarded; no state change.
- Merge ordering: merging only into the youngest entry preserves program order.
- Pointer wrap-around: pointer widths are clog2(DEPTH); count distinguishes full from empty.

Optional Feature:
- Macro: MPRC_SMB_LOAD_FWD_EN.
- When defined, adds ports:
  - fwd_addr  input  PADDR_W-3
  - fwd_mask  output  8
  - fwd_data  output  64
- Forwarding logic (combinational), per byte:
  - Value comes from the youngest valid entry whose address matches fwd_addr and whose mask bit is set.
  - fwd_mask[i] = 1 when any such entry exists; otherwise that byte is 0.
  - Reflects registered state only; stores enqueued this cycle are not visible.
- When undefined: ports and logic are absent; the block has no forwarding path.

Decomposition:
- Package mprc_cache_pkg holds:
  - constant DW_BYTES = 8;
  - typedef smb_entry_t {valid, dw_addr, data[63:0], mask[7:0]};
  - function byte_merge(old_data, new_data, mask).
- One sub-module, mprc_smb_entry: a single entry register holding its merge/allocate/clear logic. It is instantiated DEPTH times.
- The FIFO pointers and the forwarding priority search stay in the top module.

Test Plan:
- Single store, no merge: addr=0x1000, data=0x11..11, mask=0x0F with wr_ready=1 → next cycle wr_valid=1, wr_addr=0x200, wr_mask=0x0F; the cycle after, empty=1.
- Merge: with wr_ready=0, store addr=0x1000 mask=0x0F data=0xAA.., then addr=0x1004 mask=0xF0 data=0xBB.. → count=1; wr_data=0xBBBBBBBB_AAAAAAAA; wr_mask=0xFF.
- No merge into draining head: count=1 (addr 0x1000), wr_ready=1, same-cycle store to 0x1000 mask=0xF0 → allocates a new entry; count stays 1; the next write has wr_mask=0xF0.
- Full/backpressure: DEPTH=4, four distinct doubleword stores with wr_ready=0 → count=4, req_ready=0.
  - A fifth req_valid held is not accepted.
  - Raise wr_ready for one cycle → req_ready=1 the next cycle and the fifth store is accepted.
  - Then tail wraps to index 1 with data intact.
- Reset mid-operation: three entries queued, rst_n=0 for one edge → wr_valid=0, count=0, req_ready=1; no wr fire occurs after reset.
- With MPRC_SMB_LOAD_FWD_EN: entries 0x200 mask=0x01 data byte0=0x11, then 0x300, then 0x200 mask=0x03 data=0x..2222 (no merge, because 0x300 intervenes); fwd_addr=0x200 → fwd_mask=0x03 and fwd_data[15:0]=0x2222 (youngest entry wins).
